// File: rtl/regfile_ctrl.sv
// Register-file sequencer/arbiter: sweeps x1..x31 after reset, then shares read port 1 and the
// write port between the core pipeline and a debug requester, stalling the core when starved.
module regfile_ctrl #(
  parameter int unsigned         WIDTH      = 32,
  parameter int unsigned         MAX_WAIT   = 8,
  parameter logic [WIDTH-1:0]    INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       core_ra0,
  input  logic [4:0]       core_ra1,
  input  logic             core_rd1_used,
  input  logic [4:0]       core_wa,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_wd,
  output logic [WIDTH-1:0] core_rd0,
  output logic [WIDTH-1:0] core_rd1,
  output logic             core_stall,
  output logic             busy,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [4:0]       dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic [4:0]       rf_ra0,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_wa,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_wd,
  input  logic [WIDTH-1:0] rf_rd0,
  input  logic [WIDTH-1:0] rf_rd1
);

  typedef enum logic [2:0] {StInit, StIdle, StPend, StSteal, StAck} state_e;

  state_e           state_q, state_d;
  logic [4:0]       sweep_q, sweep_d;
  logic [7:0]       wait_q, wait_d;
  logic             req_we_q, req_we_d;
  logic [4:0]       req_addr_q, req_addr_d;
  logic [WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             slot_free;
  logic             do_access;

  assign core_rd0  = rf_rd0;
  assign core_rd1  = rf_rd1;
  assign dbg_rdata = rdata_q;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wait_d      = wait_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    rf_ra0      = core_ra0;
    rf_ra1      = core_ra1;
    rf_wa       = core_wa;
    rf_wd       = core_wd;
    rf_we       = core_we;
    core_stall  = 1'b0;
    busy        = 1'b0;
    dbg_ack     = 1'b0;
    do_access   = 1'b0;
    // A write needs the idle write port, a read needs the idle read port 1.
    slot_free   = req_we_q ? !core_we : !core_rd1_used;

    unique case (state_q)
      StInit: begin
        busy       = 1'b1;
        core_stall = 1'b1;
        rf_we      = 1'b1;
        rf_wa      = sweep_q;
        rf_wd      = INIT_VALUE;
        if (sweep_q == 5'd31) begin
          state_d = StIdle;
          sweep_d = 5'd1;
        end else begin
          sweep_d = sweep_q + 5'd1;
        end
      end
      StIdle: begin
        if (dbg_req) begin
          req_we_d    = dbg_we;
          req_addr_d  = dbg_addr;
          req_wdata_d = dbg_wdata;
          wait_d      = 8'd0;
          state_d     = StPend;
        end
      end
      StPend: begin
        if (slot_free) begin
          do_access = 1'b1;
          state_d   = StAck;
        end else begin
          wait_d = wait_q + 8'd1;
          if (32'(wait_d) == MAX_WAIT) begin
            state_d = StSteal;
          end
        end
      end
      StSteal: begin
        core_stall = 1'b1;
        rf_we      = 1'b0;
        do_access  = 1'b1;
        state_d    = StAck;
      end
      StAck: begin
        dbg_ack = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    if (do_access) begin
      if (req_we_q) begin
        // x0 is hard-wired; the write is dropped but still acknowledged.
        rf_we = (req_addr_q != 5'd0);
        rf_wa = req_addr_q;
        rf_wd = req_wdata_q;
      end else begin
        rf_ra1  = req_addr_q;
        rdata_d = rf_rd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      sweep_q     <= 5'd1;
      wait_q      <= 8'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 5'd0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wait_q      <= wait_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: a behavioural register-file/arbitration model checked every cycle,
// plus directed latency and data checks, then a randomized core/debug traffic phase.
module tb_regfile_ctrl;
  localparam int          W  = 32;
  localparam int          MW = 8;
  localparam logic [31:0] IV = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    core_ra0, core_ra1, core_wa;
  logic          core_rd1_used, core_we;
  logic [W-1:0]  core_wd, core_rd0, core_rd1;
  logic          core_stall, busy;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [4:0]    dbg_addr;
  logic [W-1:0]  dbg_wdata, dbg_rdata;
  logic [4:0]    rf_ra0, rf_ra1, rf_wa;
  logic          rf_we;
  logic [W-1:0]  rf_wd, rf_rd0, rf_rd1;

  int total = 0;
  int bad   = 0;

  regfile_ctrl #(.WIDTH(W), .MAX_WAIT(MW), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_ra0(core_ra0), .core_ra1(core_ra1), .core_rd1_used(core_rd1_used),
    .core_wa(core_wa), .core_we(core_we), .core_wd(core_wd),
    .core_rd0(core_rd0), .core_rd1(core_rd1), .core_stall(core_stall), .busy(busy),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
    .rf_rd0(rf_rd0), .rf_rd1(rf_rd1)
  );

  always #5 clk = ~clk;

  // Register file attached to the DUT's rf_* ports.
  logic [W-1:0] mem [32];
  logic         c_we;
  logic [4:0]   c_wa;
  logic [W-1:0] c_wd;
  assign rf_rd0 = (rf_ra0 == 5'd0) ? '0 : mem[rf_ra0];
  assign rf_rd1 = (rf_ra1 == 5'd0) ? '0 : mem[rf_ra1];
  always @(posedge clk) if (c_we && c_wa != 5'd0) mem[c_wa] <= c_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents plus one outstanding debug request.
  logic [W-1:0] gold [32];
  int           m_sweep, m_age;
  logic         m_pend, m_ack, m_we;
  logic [4:0]   m_addr;
  logic [W-1:0] m_wdata, m_rdata;

  function automatic logic [W-1:0] gold_rd(input logic [4:0] a);
    return (a == 5'd0) ? '0 : gold[a];
  endfunction

  logic         e_busy, e_forced, e_free, e_access, e_we, e_stall;
  logic [4:0]   e_wa, e_ra1;
  logic [W-1:0] e_wd;
  always_comb begin
    e_busy   = (m_sweep < 31);
    e_forced = !e_busy && m_pend && (m_age == MW + 1);
    e_free   = m_we ? !core_we : !core_rd1_used;
    e_access = !e_busy && m_pend && (e_forced || e_free);
    e_stall  = e_busy || e_forced;
    e_we     = core_we;
    e_wa     = core_wa;
    e_wd     = core_wd;
    e_ra1    = core_ra1;
    if (e_busy) begin
      e_we = 1'b1;
      e_wa = 5'(m_sweep + 1);
      e_wd = IV;
    end else if (e_access && m_we) begin
      e_we = (m_addr != 5'd0);
      e_wa = m_addr;
      e_wd = m_wdata;
    end else if (e_forced) begin
      e_we = 1'b0;
    end
    if (e_access && !m_we) e_ra1 = m_addr;
  end

  logic         n_access, n_commit, n_req, n_rwe, n_ready;
  logic [4:0]   n_cwa, n_raddr;
  logic [W-1:0] n_cwd, n_rwd, n_read_val;
  logic         last_ack;

  always @(negedge clk) begin
    c_we     <= rf_we;
    c_wa     <= rf_wa;
    c_wd     <= rf_wd;
    last_ack <= dbg_ack;
    if (!rst_n) begin
      check("rst_busy", busy, 1'b1);
      check("rst_stall", core_stall, 1'b1);
      check("rst_ack", dbg_ack, 1'b0);
      check("rst_rdata", dbg_rdata, '0);
      n_access <= 1'b0;
      n_commit <= 1'b0;
      n_req    <= 1'b0;
      n_ready  <= 1'b0;
    end else begin
      check("busy", busy, e_busy);
      check("core_stall", core_stall, e_stall);
      check("rf_we", rf_we, e_we);
      if (e_we) begin
        check("rf_wa", rf_wa, e_wa);
        check("rf_wd", rf_wd, e_wd);
      end
      check("dbg_ack", dbg_ack, m_ack);
      check("dbg_rdata", dbg_rdata, m_rdata);
      if (!e_busy) begin
        check("rf_ra0", rf_ra0, core_ra0);
        check("rf_ra1", rf_ra1, e_ra1);
        check("core_rd0", core_rd0, gold_rd(core_ra0));
        check("core_rd1", core_rd1, gold_rd(e_ra1));
      end
      n_access   <= e_access;
      n_read_val <= gold_rd(m_addr);
      n_commit   <= !e_busy && core_we && !e_forced;
      n_cwa      <= core_wa;
      n_cwd      <= core_wd;
      n_req      <= dbg_req;
      n_rwe      <= dbg_we;
      n_raddr    <= dbg_addr;
      n_rwd      <= dbg_wdata;
      n_ready    <= !e_busy && !m_pend && !m_ack;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sweep <= 0;
      m_pend  <= 1'b0;
      m_ack   <= 1'b0;
      m_age   <= 0;
      m_we    <= 1'b0;
      m_addr  <= 5'd0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else if (m_sweep < 31) begin
      gold[m_sweep + 1] <= IV;
      m_sweep <= m_sweep + 1;
    end else begin
      m_ack <= n_access;
      if (n_access) begin
        m_pend <= 1'b0;
        if (m_we && m_addr != 5'd0) gold[m_addr] <= m_wdata;
        if (!m_we) m_rdata <= n_read_val;
      end else if (m_pend) begin
        m_age <= m_age + 1;
      end
      if (n_commit && n_cwa != 5'd0) gold[n_cwa] <= n_cwd;
      if (n_ready && n_req) begin
        m_pend  <= 1'b1;
        m_age   <= 1;
        m_we    <= n_rwe;
        m_addr  <= n_raddr;
        m_wdata <= n_rwd;
      end
    end
  end

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic wait_ack(output int lat, output int stalls);
    lat    = 0;
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (core_stall) stalls++;
      if (dbg_ack) break;
    end
    check("dbg_ack_seen", dbg_ack, 1'b1);
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [W-1:0] d,
                         input bit hold, output int lat, output int stalls,
                         output logic [W-1:0] rd);
    @(posedge clk);
    #1;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
    wait_ack(lat, stalls);
    rd = dbg_rdata;
    if (!hold) begin
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
    end
  endtask

  int           lat, stalls, nb;
  logic [W-1:0] rd;
  int           pwe, pr1;

  initial begin
    rst_n = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    core_ra0 = '0; core_ra1 = '0; core_wa = '0; core_we = 1'b0; core_wd = '0;
    core_rd1_used = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(nb);
    check("init_busy_cycles", nb, 31);

    for (int a = 0; a < 32; a++) begin
      dbg_txn(1'b0, 5'(a), '0, 1'b0, lat, stalls, rd);
      check("init_read", rd, IV);
    end

    dbg_txn(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, lat, stalls, rd);
    check("wr_idle_latency", lat, 2);
    check("wr_idle_stalls", stalls, 0);
    core_ra0 = 5'd5;
    @(negedge clk);
    check("core_sees_x5", core_rd0, 32'hDEADBEEF);

    dbg_txn(1'b1, 5'd7, 32'hA5A50007, 1'b0, lat, stalls, rd);
    @(posedge clk);
    #1 core_rd1_used = 1'b1;
    dbg_txn(1'b0, 5'd7, '0, 1'b0, lat, stalls, rd);
    check("steal_latency", lat, MW + 2);
    check("steal_stalls", stalls, 1);
    check("steal_rdata", rd, 32'hA5A50007);
    core_rd1_used = 1'b0;

    dbg_txn(1'b1, 5'd0, 32'h1234, 1'b1, lat, stalls, rd);
    check("x0_wr_latency", lat, 2);
    dbg_txn(1'b0, 5'd0, '0, 1'b0, lat, stalls, rd);
    check("x0_rd_latency", lat, 2);
    check("x0_rdata", rd, 32'h0);

    fork
      dbg_txn(1'b1, 5'd9, 32'h55, 1'b0, lat, stalls, rd);
      begin
        @(posedge clk);
        #1 core_we = 1'b1; core_wa = 5'd10; core_wd = 32'hC0DE0010;
        @(posedge clk);
        #1 core_wa = 5'd11; core_wd = 32'hC0DE0011;
        @(posedge clk);
        #1 core_wa = 5'd12; core_wd = 32'hC0DE0012;
        @(posedge clk);
        #1 core_we = 1'b0;
      end
    join
    check("contend_latency", lat, 4);
    check("contend_stalls", stalls, 0);
    core_ra0 = 5'd9;  @(negedge clk); check("contend_x9", core_rd0, 32'h55);
    core_ra0 = 5'd10; @(negedge clk); check("contend_x10", core_rd0, 32'hC0DE0010);
    core_ra0 = 5'd12; @(negedge clk); check("contend_x12", core_rd0, 32'hC0DE0012);

    // Reset while a read is blocked in PEND; a request held across release waits for IDLE.
    core_rd1_used = 1'b1;
    @(posedge clk);
    #1 dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", dbg_ack, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; core_rd1_used = 1'b0;
    fork
      count_busy(nb);
      wait_ack(lat, stalls);
    join
    check("resweep_busy_cycles", nb, 31);
    check("held_req_after_init", dbg_rdata, IV);
    @(posedge clk);
    #1 dbg_req = 1'b0;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      pwe = (cyc < 800) ? 10 : (cyc < 1600) ? 50 : 95;
      pr1 = (cyc < 800) ? 95 : (cyc < 1600) ? 50 : 10;
      @(posedge clk);
      #1;
      core_ra0      = 5'($urandom);
      core_ra1      = 5'($urandom);
      core_wa       = 5'($urandom);
      core_wd       = $urandom;
      core_we       = ($urandom_range(99) < pwe);
      core_rd1_used = ($urandom_range(99) < pr1);
      if (last_ack) begin
        dbg_req = ($urandom_range(1) == 1);
      end
      if ((last_ack && dbg_req) || (!dbg_req && $urandom_range(3) == 0)) begin
        dbg_req   = 1'b1;
        dbg_we    = ($urandom_range(1) == 1);
        dbg_addr  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
        dbg_wdata = $urandom;
      end
    end
    @(posedge clk);
    #1 dbg_req = 1'b0; core_we = 1'b0; core_rd1_used = 1'b0;
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
